// File: rtl/obuf_fifo_if.sv
// Handshake bundle between upstream producer, obuf_fifo and downstream link.
// master = producer/consumer side (bench or router), slave = the buffer.
interface obuf_fifo_if #(
  parameter int unsigned PYLD_W = 1
);
  logic              valid_i;
  logic              ready_o;
  logic [PYLD_W-1:0] payload_i;
  logic              valid_o;
  logic              ready_i;
  logic [PYLD_W-1:0] payload_o;

  modport master (
    output valid_i, payload_i, ready_i,
    input  ready_o, valid_o, payload_o
  );

  modport slave (
    input  valid_i, payload_i, ready_i,
    output ready_o, valid_o, payload_o
  );
endinterface

// File: rtl/obuf_fifo.sv
// DEPTH-entry output buffer FIFO with registered handshake, occupancy and almost-full.
// Optional OBUF_FIFO_STALL_CNT_EN adds a saturating 16-bit stall cycle counter.
module obuf_fifo #(
  parameter  int unsigned PYLD_W   = 1,
  parameter  int unsigned DEPTH    = 4,
  parameter  int unsigned AFULL_TH = DEPTH - 1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  obuf_fifo_if.slave    bus,
  output logic [CW-1:0] count_o,
`ifdef OBUF_FIFO_STALL_CNT_EN
  output logic [15:0]   stall_cnt_o,
`endif
  output logic          afull_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PYLD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]     count_nxt;
  logic              push, pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    push       = bus.valid_i & bus.ready_o;
    pop        = bus.valid_o & bus.ready_i;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_o;
    if (push) wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    if (pop)  rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    if (push && !pop)      count_nxt = count_o + CW'(1);
    else if (pop && !push) count_nxt = count_o - CW'(1);
  end

  // Flags are registered from the next count so they move on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      bus.valid_o <= 1'b0;
      bus.ready_o <= 1'b1;
      afull_o     <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count_o     <= count_nxt;
      bus.valid_o <= (count_nxt != '0);
      bus.ready_o <= (count_nxt != CW'(DEPTH));
      afull_o     <= (count_nxt >= CW'(AFULL_TH));
    end
  end

  // Storage is deliberately not reset; head is only meaningful while valid_o.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.payload_i;
  end

  assign bus.payload_o = mem[rd_ptr];

`ifdef OBUF_FIFO_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (bus.valid_o && !bus.ready_i && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_obuf_fifo.sv
// Directed bench for obuf_fifo: DEPTH=4 instance for fill/drain/stream/reset,
// DEPTH=3 instance for pointer wrap with random downstream backpressure.
module tb_obuf_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  obuf_fifo_if #(.PYLD_W(8)) bus_a ();
  obuf_fifo_if #(.PYLD_W(8)) bus_b ();

  logic [2:0] count_a;
  logic [1:0] count_b;
  logic       afull_a, afull_b;
`ifdef OBUF_FIFO_STALL_CNT_EN
  logic [15:0] stall_a, stall_b;
`endif

  obuf_fifo #(.PYLD_W(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .count_o(count_a),
`ifdef OBUF_FIFO_STALL_CNT_EN
    .stall_cnt_o(stall_a),
`endif
    .afull_o(afull_a)
  );

  obuf_fifo #(.PYLD_W(8), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .count_o(count_b),
`ifdef OBUF_FIFO_STALL_CNT_EN
    .stall_cnt_o(stall_b),
`endif
    .afull_o(afull_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int unsigned mcount, pushed, popped;
  logic [7:0]  q[$];
  logic [7:0]  exp_list[4];
  logic        vin, rin, pm, popm;

  initial begin
    bus_a.valid_i = 1'b0; bus_a.payload_i = '0; bus_a.ready_i = 1'b0;
    bus_b.valid_i = 1'b0; bus_b.payload_i = '0; bus_b.ready_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_valid", 32'(bus_a.valid_o), 32'd0);
    chk("rst_ready", 32'(bus_a.ready_o), 32'd1);
    chk("rst_afull", 32'(afull_a), 32'd0);
    tick;
    rst_n = 1'b1;

    // Fill with downstream blocked
    for (int i = 0; i < 4; i++) begin
      bus_a.valid_i   = 1'b1;
      bus_a.payload_i = 8'(8'hA + i);
      tick;
      chk("fill_count", 32'(count_a), 32'(i + 1));
      chk("fill_afull", 32'(afull_a), 32'((i + 1) >= 3));
      chk("fill_ready", 32'(bus_a.ready_o), 32'((i + 1) != 4));
    end
    bus_a.payload_i = 8'hE;
    tick;
    chk("fifth_count", 32'(count_a), 32'd4);
    chk("fifth_ready", 32'(bus_a.ready_o), 32'd0);
    chk("fifth_head", 32'(bus_a.payload_o), 32'hA);

    // Drain order
    bus_a.valid_i = 1'b0;
    bus_a.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(bus_a.valid_o), 32'd1);
      chk("drain_data", 32'(bus_a.payload_o), 32'(8'hA + i));
      tick;
      chk("drain_count", 32'(count_a), 32'(3 - i));
    end
    chk("drain_empty", 32'(bus_a.valid_o), 32'd0);
    bus_a.ready_i = 1'b0;

    // Full plus pop: pop only, push lands one cycle later
    for (int i = 1; i <= 4; i++) begin
      bus_a.valid_i   = 1'b1;
      bus_a.payload_i = 8'(i);
      tick;
    end
    bus_a.payload_i = 8'h55;
    bus_a.ready_i   = 1'b1;
    tick;
    chk("fp_count", 32'(count_a), 32'd3);
    chk("fp_head", 32'(bus_a.payload_o), 32'd2);
    chk("fp_ready", 32'(bus_a.ready_o), 32'd1);
    bus_a.ready_i = 1'b0;
    tick;
    chk("fp_push_count", 32'(count_a), 32'd4);
    bus_a.valid_i = 1'b0;
    bus_a.ready_i = 1'b1;
    exp_list[0] = 8'd2; exp_list[1] = 8'd3; exp_list[2] = 8'd4; exp_list[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk("fp_data", 32'(bus_a.payload_o), 32'(exp_list[i]));
      tick;
    end
    chk("fp_empty", 32'(count_a), 32'd0);

    // Streaming at one transfer per cycle
    bus_a.valid_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus_a.payload_i = 8'(k);
      tick;
      chk("strm_data", 32'(bus_a.payload_o), 32'(k));
      chk("strm_count", 32'(count_a), 32'd1);
    end
    bus_a.valid_i = 1'b0;
    tick;
    chk("strm_end", 32'(count_a), 32'd0);
    bus_a.ready_i = 1'b0;

    // Odd depth wrap against a scoreboard
    mcount = 0; pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
      chk("b_count", 32'(count_b), 32'(mcount));
      chk("b_le3", 32'(count_b <= 2'd3 && mcount <= 3), 32'd1);
      chk("b_valid", 32'(bus_b.valid_o), 32'(mcount != 0));
      chk("b_afull", 32'(afull_b), 32'(mcount >= 2));
      if (mcount != 0) chk("b_data", 32'(bus_b.payload_o), 32'(q[0]));
      vin  = (pushed < 10);
      rin  = 1'($urandom_range(0, 1));
      bus_b.valid_i   = vin;
      bus_b.payload_i = 8'(8'h30 + pushed);
      bus_b.ready_i   = rin;
      pm   = vin && (mcount != 3);
      popm = (mcount != 0) && rin;
      if (popm) begin void'(q.pop_front()); popped++; end
      if (pm) begin q.push_back(8'(8'h30 + pushed)); pushed++; end
      mcount = mcount + 32'(pm) - 32'(popm);
      tick;
    end
    chk("b_done", popped, 32'd10);
    bus_b.valid_i = 1'b0;
    bus_b.ready_i = 1'b0;

    // Mid-traffic asynchronous reset
    bus_a.valid_i = 1'b1; bus_a.payload_i = 8'h11; tick;
    bus_a.payload_i = 8'h22; tick;
    bus_a.valid_i = 1'b0;
    chk("mr_pre", 32'(count_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_count", 32'(count_a), 32'd0);
    chk("mr_valid", 32'(bus_a.valid_o), 32'd0);
    chk("mr_ready", 32'(bus_a.ready_o), 32'd1);
    chk("mr_afull", 32'(afull_a), 32'd0);
`ifdef OBUF_FIFO_STALL_CNT_EN
    chk("mr_stall", 32'(stall_a), 32'd0);
`endif
    tick;
    rst_n = 1'b1;

    // Stall counting then reset clears it
    bus_a.valid_i = 1'b1; bus_a.payload_i = 8'h77; tick;
    bus_a.valid_i = 1'b0;
    chk("st_head", 32'(bus_a.payload_o), 32'h77);
    chk("st_count", 32'(count_a), 32'd1);
    repeat (5) tick;
`ifdef OBUF_FIFO_STALL_CNT_EN
    chk("st_stall5", 32'(stall_a), 32'd5);
`endif
    chk("st_hold", 32'(bus_a.payload_o), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("st_rst_count", 32'(count_a), 32'd0);
    chk("st_rst_valid", 32'(bus_a.valid_o), 32'd0);
`ifdef OBUF_FIFO_STALL_CNT_EN
    chk("st_rst_stall", 32'(stall_a), 32'd0);
`endif
    tick;
    rst_n = 1'b1;
    bus_a.valid_i = 1'b1; bus_a.payload_i = 8'h99; tick;
    bus_a.valid_i = 1'b0;
    chk("post_head", 32'(bus_a.payload_o), 32'h99);
    chk("post_count", 32'(count_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/obuf_fifo.md
# obuf_fifo

Parametrised output buffer placed between a router/user-logic output port and the link toward the next mesh node. It generalises the single-entry output buffer to a DEPTH-entry FIFO with full throughput: one push and one pop per cycle, including both in the same cycle. It also adds occupancy and almost-full reporting. All outputs are driven from registers, so there is no combinational path from ready_i to ready_o or from valid_i to valid_o.

## Interface

Parameters:

- PYLD_W, 1: payload width in bits, ≥1.
- DEPTH, 4: number of entries, ≥2. Any integer value is allowed; a power of two is not required.
- AFULL_TH, DEPTH-1: afull_o asserts when count ≥ AFULL_TH. Legal range is 1..DEPTH.

Ports (one clock; reset is asynchronous and active-low):

- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- valid_i, input, 1: upstream data valid.
- ready_o, output, 1: buffer can accept data; equals (count != DEPTH).
- payload_i, input, PYLD_W: upstream payload.
- valid_o, output, 1: head entry valid; equals (count != 0).
- ready_i, input, 1: downstream accepts the head entry.
- payload_o, output, PYLD_W: head entry, mem[rd_ptr].
- count_o, output, CW = $clog2(DEPTH+1): current occupancy, 0..DEPTH.
- afull_o, output, 1: count ≥ AFULL_TH.
- stall_cnt_o, output, 16: present only with OBUF_FIFO_STALL_CNT_EN; see Configuration.

## Operation

- push = valid_i & ready_o. The payload is written to mem[wr_ptr], then wr_ptr advances.
- pop = valid_o & ready_i. rd_ptr advances.
- Pointers are $clog2(DEPTH) bits wide and wrap explicitly from DEPTH-1 to 0. Modulo-2^n wrap is not used, so non-power-of-two DEPTH works.
- count is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on both or neither.
- Full (count == DEPTH): ready_o = 0, so no push occurs even if a pop happens in the same cycle. ready_o rises the cycle after the pop.
- Empty (count == 0): valid_o = 0 and no pop occurs. The pending push becomes visible on valid_o the next cycle; there is no bypass.
- Simultaneous push and pop at 0 < count < DEPTH: count holds and both pointers advance. With count == 1, the new entry becomes the head next cycle.
- valid_o is never deasserted while ready_i = 0. payload_o remains stable while valid_o = 1 and ready_i = 0.
- Storage array is not reset. payload_o is don't-care whenever valid_o = 0.
- Data ordering is strict FIFO: no drop, no duplication.

## Timing

- Reset values (asynchronous, immediate on rst_n low): wr_ptr = rd_ptr = 0, count_o = 0, valid_o = 0, ready_o = 1, afull_o = 0, stall_cnt_o = 0. payload_o is undefined.
- Reset asserted mid-traffic discards all entries. The first push after release is the first data out.
- Latency: a push in cycle N gives valid_o = 1 with that payload in cycle N+1, minimum.
- Throughput: 1 transfer/cycle in steady state when ready_i is held high and count is between 1 and DEPTH-1.
- count_o, afull_o, ready_o and valid_o all change on the same edge as count.

## Configuration

- Macro OBUF_FIFO_STALL_CNT_EN.
- Defined: port stall_cnt_o exists. A 16-bit counter increments each cycle that valid_o & ~ready_i holds. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan

- Reset then fill: DEPTH = 4, ready_i = 0, push 0xA,0xB,0xC,0xD on four consecutive cycles.
  - count_o reaches 4 and ready_o = 0 from the next cycle.
  - afull_o = 1 from the cycle count reaches 3.
  - A fifth valid_i is not accepted.
- Drain order: from full, set ready_i = 1 for 4 cycles → payload_o is 0xA,0xB,0xC,0xD in order, then valid_o = 0 and count_o = 0.
- Streaming: valid_i and ready_i held high for 20 cycles with an incrementing payload.
  - Output is the same sequence, lagging by 1 cycle.
  - count_o stays at 1.
- Full plus pop: at count = 4, assert valid_i and ready_i together.
  - Pop only: count_o = 3 next cycle, and the pushed data is not captured.
  - The push is accepted the following cycle.
- Wrap and odd depth: DEPTH = 3, push/pop 10 entries with random ready_i → order preserved across multiple pointer wraps, and count_o never exceeds 3.
- Mid-traffic reset and stall count (with OBUF_FIFO_STALL_CNT_EN):
  - Hold valid_o high with ready_i = 0 for 5 cycles → stall_cnt_o = 5.
  - Pulse rst_n low → outputs return to reset values immediately, with stall_cnt_o = 0 and count_o = 0.
